// File: rtl/conv_layer_sequencer.sv
// Raster-scan read sequencer for a KxK convolution engine: issues row-major pixel reads,
// tags window validity and times result writes through a fixed-latency delay line.
module conv_layer_sequencer #(
    parameter int IMG_W    = 100,
    parameter int IMG_H    = 100,
    parameter int K        = 3,
    parameter int PIPE_LAT = 4,
    parameter int ADDR_W   = 14
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Stall,
    output logic [ADDR_W-1:0] Rd_Addr,
    output logic              Rd_En,
    output logic              Shift_En,
    output logic              Win_Valid,
    output logic              Out_Wr,
    output logic [ADDR_W-1:0] Out_Addr,
    output logic              Busy,
    output logic              Done
);

    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int CNT_W = $clog2(PIPE_LAT + 2) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_MIN   = ROW_W'(K - 1);
    localparam logic [COL_W-1:0]  COL_MIN   = COL_W'(K - 1);
    localparam logic [CNT_W-1:0]  DRAIN_END = CNT_W'(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [ROW_W-1:0]    row_r;
    logic [COL_W-1:0]    col_r;
    logic [ADDR_W-1:0]   addr_cnt_r;
    logic [ROW_W-1:0]    tag_row_r;
    logic [COL_W-1:0]    tag_col_r;
    logic [CNT_W-1:0]    drain_cnt_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                rd_en_r;
    logic                busy_r;
    logic                done_r;
    logic                shift_en_r;
    logic                win_valid_r;
    logic [PIPE_LAT-1:0] wv_pipe_r;
    logic [ADDR_W-1:0]   out_addr_r;

    // Frame FSM: read address generation, drain timing and Done/Busy outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= IDLE;
            row_r       <= '0;
            col_r       <= '0;
            addr_cnt_r  <= '0;
            tag_row_r   <= '0;
            tag_col_r   <= '0;
            drain_cnt_r <= '0;
            rd_addr_r   <= '0;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rd_en_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (Start) begin
                        state_r <= READ;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                READ: begin
                    if (!Stall) begin
                        rd_en_r    <= 1'b1;
                        rd_addr_r  <= addr_cnt_r;
                        tag_row_r  <= row_r;
                        tag_col_r  <= col_r;
                        addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
                        if (col_r == COL_LAST) begin
                            col_r <= '0;
                            row_r <= row_r + ROW_W'(1);
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                        if (addr_cnt_r == LAST_ADDR) begin
                            state_r     <= DRAIN;
                            drain_cnt_r <= '0;
                        end
                    end else begin
                        // Stalled: address and counters hold, only the strobe drops.
                        rd_en_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    rd_en_r <= 1'b0;
                    if (drain_cnt_r == DRAIN_END) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    rd_en_r     <= 1'b0;
                    row_r       <= '0;
                    col_r       <= '0;
                    addr_cnt_r  <= '0;
                    rd_addr_r   <= '0;
                    drain_cnt_r <= '0;
                end
                default: begin
                    state_r <= IDLE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Window pipeline: shift strobe and window flag follow each returned pixel, then the
    // flag walks an unstallable PIPE_LAT-deep line to become the result write strobe.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            shift_en_r  <= 1'b0;
            win_valid_r <= 1'b0;
            wv_pipe_r   <= '0;
        end else begin
            shift_en_r   <= rd_en_r;
            win_valid_r  <= rd_en_r && (tag_row_r >= ROW_MIN) && (tag_col_r >= COL_MIN);
            wv_pipe_r[0] <= win_valid_r;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wv_pipe_r[i] <= wv_pipe_r[i-1];
            end
        end
    end

    // Result address counter, rewound when the frame returns to IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_addr_r <= '0;
        end else if (state_r == DONE) begin
            out_addr_r <= '0;
        end else if (wv_pipe_r[PIPE_LAT-1]) begin
            out_addr_r <= out_addr_r + ADDR_W'(1);
        end
    end

    assign Rd_Addr   = rd_addr_r;
    assign Rd_En     = rd_en_r;
    assign Shift_En  = shift_en_r;
    assign Win_Valid = win_valid_r;
    assign Out_Wr    = wv_pipe_r[PIPE_LAT-1];
    assign Out_Addr  = out_addr_r;
    assign Busy      = busy_r;
    assign Done      = done_r;

endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameter IMG_W, default 100, input image width in pixels.
REQ-002 Parameter IMG_H, default 100, input image height in pixels.
REQ-003 Parameter K, default 3, square kernel size.
REQ-004 Parameter PIPE_LAT, default 4, cycles from window-valid to convolution result ready (PIPE_LAT >= 1).
REQ-005 Parameter ADDR_W, default 14, address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-006 Clk  input  1  single clock; all state on rising edge.
REQ-007 Rst  input  1  asynchronous, active-low reset.
REQ-008 Start  input  1  begin one frame; sampled only in IDLE.
REQ-009 Stall  input  1  downstream back-pressure; inhibits new pixel reads.
REQ-010 Rd_Addr  output  ADDR_W  input-memory read address (row-major).
REQ-011 Rd_En  output  1  read strobe; memory data returns one cycle later.
REQ-012 Shift_En  output  1  line-buffer/window shift strobe, aligned with returned pixel.
REQ-013 Win_Valid  output  1  window register holds a full KxK valid window this cycle.
REQ-014 Out_Wr  output  1  convolution result write strobe.
REQ-015 Out_Addr  output  ADDR_W  result-memory write address, valid with Out_Wr.
REQ-016 Busy  output  1  high in any state except IDLE.
REQ-017 Done  output  1  one-cycle frame-complete pulse.

Function
REQ-018 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-019 IDLE -> READ on Start=1; Start in any other state SHALL be ignored.
REQ-020 In READ with Stall=0: Rd_En=1 and Rd_Addr=row*IMG_W+col; col increments, wrapping IMG_W-1 -> 0 with row increment.
REQ-021 In READ with Stall=1: Rd_En=0; row/col/Rd_Addr hold; in-flight pipeline continues.
REQ-022 READ -> DRAIN in the cycle after the read of address IMG_W*IMG_H-1 is issued.
REQ-023 Shift_En SHALL equal Rd_En delayed one cycle; row/col tags SHALL be delayed alongside it.
REQ-024 Win_Valid = Shift_En AND tagged row >= K-1 AND tagged col >= K-1.
REQ-025 Out_Wr SHALL equal Win_Valid delayed exactly PIPE_LAT cycles; this delay line is never stalled.
REQ-026 Out_Addr SHALL start at 0 per frame and increment by 1 after each Out_Wr cycle; total Out_Wr pulses per frame = (IMG_W-K+1)*(IMG_H-K+1) (9604 at defaults).
REQ-027 DRAIN SHALL last until the Shift_En and Out_Wr delay lines are empty (PIPE_LAT+1 cycles after the last Rd_En), then -> DONE.
REQ-028 DONE SHALL assert Done for exactly one cycle, then -> IDLE; Out_Addr, row, col cleared on entering IDLE.
REQ-029 Stall in DRAIN or DONE SHALL have no effect.
REQ-030 Start and Stall both high on the IDLE->READ edge: transition occurs, first read waits until Stall=0.
REQ-031 Rd_Addr SHALL be 0 whenever Rd_En=0 in IDLE; otherwise it holds its last value.

Reset
REQ-032 Rst=0 SHALL immediately force IDLE, row=col=0, Rd_Addr=0, Out_Addr=0, clear all delay lines, and drive Rd_En, Shift_En, Win_Valid, Out_Wr, Busy, Done to 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no further Out_Wr; a later Start begins a fresh frame from address 0.
REQ-034 Outputs SHALL be deterministic from the first rising Clk after Rst deasserts.

Verification
REQ-035 Start pulse, Stall=0, defaults -> 10000 consecutive Rd_En (addr 0..9999), 9604 Out_Wr with Out_Addr 0..9603, Done one cycle PIPE_LAT+2 cycles after last Rd_En, then Busy=0.
REQ-036 First window: pixel addr 202 (row 2, col 2) read at cycle t -> Win_Valid at t+1, Out_Wr with Out_Addr=0 at t+1+PIPE_LAT; cols 0-1 of every row never give Win_Valid.
REQ-037 Stall=1 for 5 cycles at addr 150 -> Rd_Addr holds 150, Rd_En=0 those cycles, no skipped or duplicated addresses, total Out_Wr still 9604.
REQ-038 Start asserted during READ and DRAIN -> no restart, counts unchanged; Start during Done cycle ignored.
REQ-039 Rst=0 at Rd_Addr=5000 -> all outputs 0 immediately; new Start -> Rd_Addr 0, full 9604 results.
REQ-040 IMG_W=IMG_H=5, K=3, PIPE_LAT=1 -> 25 reads, 9 Out_Wr with Out_Addr 0..8, single Done pulse.
